// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 bus writer.
//   lcd_state_e  - write-engine phase (IDLE/SETUP/PULSE/HOLD/WAIT)
//   lcd_nib_e    - nibble select for the 4-bit bus variant
//   CMD_CLEAR / CMD_HOME - instructions that need the long execution wait
//   LCD_TMR_W    - width of the phase down-counter
package lcd_pkg;

  localparam int unsigned LCD_TMR_W = 16;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  typedef enum logic {
    NIB_HI = 1'b0,
    NIB_LO = 1'b1
  } lcd_nib_e;

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) run long on the controller.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || ((data & 8'hFE) == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter that times each bus phase.
//   clk, rst     - clock, asynchronous active-high reset
//   i_load       - load i_value this cycle (takes priority over counting)
//   i_value      - N-1 for an N-cycle phase
//   o_done_c     - combinational flag, counter is at zero
module lcd_phase_timer
  import lcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [LCD_TMR_W-1:0] i_value,
  output logic                 o_done_c
);

  logic [LCD_TMR_W-1:0] r_cnt;

  // Counts down and parks at zero until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LCD_TMR_W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: pin-level write engine for an HD44780-class character LCD.
// Accepts one byte per req_valid/req_ready handshake, drives RS/DATA with
// setup and hold around a generated E pulse, then stays busy for the
// controller's execution time.
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   req_rs, req_data    - register select (1 = data) and byte to write
//   busy                - high whenever the engine is not IDLE
//   LCD_E, LCD_RS, LCD_RW, LCD_DATA - LCD pins (RW tied low, write-only)
// Build option: define LCD_4BIT_EN to send each byte as two nibbles on
// LCD_DATA[7:4] (high nibble first) with a single execution wait at the end.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PULSE     = 12,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 40,
  parameter int unsigned T_EXEC_LONG = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam logic [LCD_TMR_W-1:0] LD_SETUP = LCD_TMR_W'(T_SETUP - 1);
  localparam logic [LCD_TMR_W-1:0] LD_PULSE = LCD_TMR_W'(T_PULSE - 1);
  localparam logic [LCD_TMR_W-1:0] LD_HOLD  = LCD_TMR_W'(T_HOLD - 1);
  localparam logic [LCD_TMR_W-1:0] LD_EXEC  = LCD_TMR_W'(T_EXEC - 1);
  localparam logic [LCD_TMR_W-1:0] LD_LONG  = LCD_TMR_W'(T_EXEC_LONG - 1);

  lcd_state_e r_state, w_state_nxt;
  logic       r_ready, w_ready_nxt;
  logic       r_busy;
  logic       r_e, w_e_nxt;
  logic       r_rs, w_rs_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic       r_long, w_long_nxt;
`ifdef LCD_4BIT_EN
  lcd_nib_e   r_nib, w_nib_nxt;
  logic [3:0] r_lo_nib, w_lo_nib_nxt;
`endif

  logic                 w_load;
  logic [LCD_TMR_W-1:0] w_value;
  logic                 w_done_c;

  lcd_phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_value  (w_value),
    .o_done_c (w_done_c)
  );

  // State and registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_e      <= 1'b0;
      r_rs     <= 1'b0;
      r_data   <= 8'h00;
      r_long   <= 1'b0;
`ifdef LCD_4BIT_EN
      r_nib    <= NIB_HI;
      r_lo_nib <= 4'h0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_e      <= w_e_nxt;
      r_rs     <= w_rs_nxt;
      r_data   <= w_data_nxt;
      r_long   <= w_long_nxt;
`ifdef LCD_4BIT_EN
      r_nib    <= w_nib_nxt;
      r_lo_nib <= w_lo_nib_nxt;
`endif
    end
  end

  // Next state, next pin values and phase-timer loads.
  always_comb begin
    w_state_nxt  = r_state;
    w_ready_nxt  = 1'b0;
    w_e_nxt      = 1'b0;
    w_rs_nxt     = r_rs;
    w_data_nxt   = r_data;
    w_long_nxt   = r_long;
    w_load       = 1'b0;
    w_value      = '0;
`ifdef LCD_4BIT_EN
    w_nib_nxt    = r_nib;
    w_lo_nib_nxt = r_lo_nib;
`endif

    case (r_state)
      ST_IDLE: begin
        if (r_ready && req_valid) begin
          w_state_nxt = ST_SETUP;
          w_rs_nxt    = req_rs;
          w_long_nxt  = is_long_cmd(req_rs, req_data);
          w_load      = 1'b1;
          w_value     = LD_SETUP;
`ifdef LCD_4BIT_EN
          w_data_nxt   = {req_data[7:4], 4'h0};
          w_lo_nib_nxt = req_data[3:0];
          w_nib_nxt    = NIB_HI;
`else
          w_data_nxt   = req_data;
`endif
        end else begin
          w_ready_nxt = 1'b1;
        end
      end

      ST_SETUP: begin
        if (w_done_c) begin
          w_state_nxt = ST_PULSE;
          w_e_nxt     = 1'b1;
          w_load      = 1'b1;
          w_value     = LD_PULSE;
        end
      end

      ST_PULSE: begin
        w_e_nxt = 1'b1;
        if (w_done_c) begin
          w_state_nxt = ST_HOLD;
          w_e_nxt     = 1'b0;
          w_load      = 1'b1;
          w_value     = LD_HOLD;
        end
      end

      ST_HOLD: begin
        if (w_done_c) begin
`ifdef LCD_4BIT_EN
          // High nibble done: go straight to the low nibble's setup.
          if (r_nib == NIB_HI) begin
            w_state_nxt = ST_SETUP;
            w_nib_nxt   = NIB_LO;
            w_data_nxt  = {r_lo_nib, 4'h0};
            w_load      = 1'b1;
            w_value     = LD_SETUP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_load      = 1'b1;
            w_value     = r_long ? LD_LONG : LD_EXEC;
          end
`else
          w_state_nxt = ST_WAIT;
          w_load      = 1'b1;
          w_value     = r_long ? LD_LONG : LD_EXEC;
`endif
        end
      end

      ST_WAIT: begin
        if (w_done_c) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign req_ready = r_ready;
  assign busy      = r_busy;
  assign LCD_E     = r_e;
  assign LCD_RS    = r_rs;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = r_data;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: the driver pushes expected E pulses
// and ready-return cycles on each accept; a negedge monitor pops and compares.
module tb_lcd_bus_writer;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 2;
  localparam int X  = 40;
  localparam int XL = 1600;
  localparam int PH = S + P + H;
`ifdef LCD_4BIT_EN
  localparam int NNIB = 2;
`else
  localparam int NNIB = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       busy;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  lcd_bus_writer #(
    .T_SETUP     (S),
    .T_PULSE     (P),
    .T_HOLD      (H),
    .T_EXEC      (X),
    .T_EXEC_LONG (XL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .busy      (busy),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_DATA  (LCD_DATA)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
  } pulse_t;

  pulse_t     e_q[$];
  int         rdy_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_bus = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Expected pin activity for a byte accepted at edge k.
  task automatic expect_write(input logic rs, input logic [7:0] d, input int k, input bit lng);
    pulse_t p;
    p.rs = rs;
`ifdef LCD_4BIT_EN
    p.data = {d[7:4], 4'h0}; p.rise = k + S;      p.fall = k + S + P;      e_q.push_back(p);
    p.data = {d[3:0], 4'h0}; p.rise = k + PH + S; p.fall = k + PH + S + P; e_q.push_back(p);
`else
    p.data = d;              p.rise = k + S;      p.fall = k + S + P;      e_q.push_back(p);
`endif
    last_bus = p.data;
    rdy_q.push_back(k + NNIB * PH + (lng ? XL : X));
  endtask

  // Present a request and wait (bounded) for it to be accepted; k = accept edge.
  task automatic send(input logic rs, input logic [7:0] d, input bit lng,
                      input bit scramble, output int k);
    int         bus_chg;
    logic [7:0] d0;
    bus_chg   = 0;
    d0        = last_bus;
    k         = -1;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (req_ready) begin
        k = cyc + 1;
        expect_write(req_rs, req_data, k, lng);
        break;
      end
      if (LCD_DATA != d0) bus_chg++;
      if (scramble) req_data = req_data ^ 8'h15;
    end
    if (k < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: no accept for 0x%0h within 4000 cycles", d);
    end else begin
      @(posedge clk);
      #1;
    end
    if (scramble) chk("bus_stable_in_wait", bus_chg, 0);
  endtask

  // Monitor: pops expectations when E or req_ready edges appear.
  logic   prev_e   = 1'b0;
  logic   prev_rdy = 1'b0;
  bit     in_pulse = 1'b0;
  int     hold_cyc = -1;
  pulse_t cur;

  always @(negedge clk) begin
    if (rst) begin
      e_q.delete();
      rdy_q.delete();
      prev_e   = 1'b0;
      prev_rdy = 1'b0;
      in_pulse = 1'b0;
      hold_cyc = -1;
    end else begin
      if (LCD_E && !prev_e) begin
        if (e_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL e_unexpected: E rose at cycle %0d with nothing expected", cyc);
        end else begin
          cur      = e_q.pop_front();
          in_pulse = 1'b1;
          chk("e_rise_cycle", cyc, cur.rise);
          chk("e_rise_rs", int'(LCD_RS), int'(cur.rs));
          chk("e_rise_data", int'(LCD_DATA), int'(cur.data));
          chk("e_rise_busy", int'(busy), 1);
        end
      end else if (LCD_E && in_pulse) begin
        chk("e_pulse_data", int'(LCD_DATA), int'(cur.data));
      end
      if (!LCD_E && prev_e && in_pulse) begin
        chk("e_fall_cycle", cyc, cur.fall);
        in_pulse = 1'b0;
        hold_cyc = cyc + H - 1;
      end
      if (cyc == hold_cyc) begin
        chk("hold_data", int'(LCD_DATA), int'(cur.data));
        chk("hold_rs", int'(LCD_RS), int'(cur.rs));
        hold_cyc = -1;
      end
      if (req_ready && !prev_rdy) begin
        if (rdy_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL ready_unexpected: ready rose at cycle %0d", cyc);
        end else begin
          chk("ready_rise_cycle", cyc, rdy_q.pop_front());
          chk("ready_rise_busy", int'(busy), 0);
        end
      end
      prev_e   = LCD_E;
      prev_rdy = req_ready;
    end
  end

  localparam int SP_N = NNIB * PH + X + 1;
  localparam int SP_L = NNIB * PH + XL + 1;

  int k1, k2, k3, k4, k5, k6, k7, k8, k9, k10, k11, k12, k13;
  bit seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_e", int'(LCD_E), 0);
    chk("rst_rs", int'(LCD_RS), 0);
    chk("rst_rw", int'(LCD_RW), 0);
    chk("rst_data", int'(LCD_DATA), 0);
    #1 rst = 1'b0;
    rdy_q.push_back(cyc + 1);

    send(1'b0, 8'h38, 1'b0, 1'b0, k1);
    send(1'b1, 8'h48, 1'b0, 1'b0, k2);
    chk("spacing_38", k2 - k1, SP_N);
    send(1'b0, 8'h01, 1'b1, 1'b0, k3);
    chk("spacing_48", k3 - k2, SP_N);
    send(1'b0, 8'h80, 1'b0, 1'b0, k4);
    chk("spacing_clear", k4 - k3, SP_L);
    send(1'b0, 8'h04, 1'b0, 1'b0, k5);
    chk("spacing_80", k5 - k4, SP_N);
    send(1'b0, 8'h03, 1'b1, 1'b0, k6);
    chk("spacing_04", k6 - k5, SP_N);
    send(1'b0, 8'h00, 1'b0, 1'b0, k7);
    chk("spacing_home03", k7 - k6, SP_L);
    send(1'b1, 8'h01, 1'b0, 1'b0, k8);
    chk("spacing_00", k8 - k7, SP_N);
    send(1'b0, 8'h02, 1'b1, 1'b0, k9);
    chk("spacing_data01", k9 - k8, SP_N);
    send(1'b1, 8'h41, 1'b0, 1'b0, k10);
    chk("spacing_home02", k10 - k9, SP_L);

    // Valid stays high through WAIT while the byte keeps changing.
    repeat (NNIB * PH) @(posedge clk);
    #1;
    send(1'b1, 8'h61, 1'b0, 1'b1, k11);
    chk("spacing_wait_valid", k11 - k10, SP_N);
    req_valid = 1'b0;

    // Reset while E is high.
    send(1'b1, 8'h33, 1'b0, 1'b0, k12);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (LCD_E) begin
        seen = 1'b1;
        break;
      end
    end
    chk("e_high_before_rst", int'(seen), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_e", int'(LCD_E), 0);
    chk("async_rst_rs", int'(LCD_RS), 0);
    chk("async_rst_data", int'(LCD_DATA), 0);
    chk("async_rst_ready", int'(req_ready), 0);
    chk("async_rst_busy", int'(busy), 0);
    last_bus = 8'h00;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    rdy_q.push_back(cyc + 1);

    send(1'b0, 8'h0C, 1'b0, 1'b0, k13);
    req_valid = 1'b0;

    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (e_q.size() == 0 && rdy_q.size() == 0) break;
    end
    @(negedge clk);
    chk("drain_e_q", e_q.size(), 0);
    chk("drain_rdy_q", rdy_q.size(), 0);
    chk("final_ready", int'(req_ready), 1);
    chk("final_bus", int'(LCD_DATA), int'(last_bus));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
